rr_grant_sel: RTL and testbench

Four-way round-robin arbiter that sits directly upstream of the 2-to-4 line decoder. It accepts four request lines and produces a registered 2-bit grant index `S` with a valid flag. Downstream logic feeds `S` into `decoder2_4` and gates the one-hot result with `GV` to form per-requester grant strobes. Grants are fair, rotating, and held until the owner releases them, with an optional hold-time limit.

---
 rtl/rr_grant_sel_pkg.sv | 20 ++
 rtl/rr_grant_sel_pick.sv | 37 +++
 rtl/rr_grant_sel.sv | 135 +++++++++++++
 tb/tb_rr_grant_sel.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_sel_pkg.sv
// Shared types and constants for the round-robin grant selector.
package rr_pkg;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    // One-hot mask for a requester index; used to exclude the current owner.
    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] mask;
        mask = {NREQ{1'b0}};
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rr_grant_sel_pick.sv
// Combinational rotating-priority finder: first request at or after PTR
// (mod NREQ) that is not excluded.
module rr_pick
    import rr_pkg::*;
(
    input  logic [NREQ-1:0] REQ,
    input  logic [IDXW-1:0] PTR,
    input  logic [NREQ-1:0] EXCL,
    output logic            HIT,
    output logic [IDXW-1:0] IDX
);

    logic [NREQ-1:0] cand_s;
    logic [IDXW-1:0] pos_s;
    logic            bit_s;
    logic            hit_s;
    logic [IDXW-1:0] idx_s;

    // Scan from the farthest position back to PTR so the nearest hit wins.
    always_comb begin
        cand_s = REQ & ~EXCL;
        hit_s  = 1'b0;
        idx_s  = PTR;
        pos_s  = PTR;
        bit_s  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos_s = PTR + IDXW'(k);
            bit_s = cand_s[pos_s];
            hit_s = hit_s | bit_s;
            idx_s = bit_s ? pos_s : idx_s;
        end
    end

    assign HIT = hit_s;
    assign IDX = idx_s;

endmodule

// File: rtl/rr_grant_sel.sv
// Four-way round-robin arbiter producing a registered grant index S and
// valid flag GV for the downstream 2-to-4 decoder.
// Optional feature: define RR_TIMEOUT_EN to force rotation after HOLD_MAX
// consecutive grant cycles when another requester is waiting.
module rr_grant_sel
    import rr_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNTW     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] REQ,
    output logic [IDXW-1:0] S,
    output logic            GV,
    output logic            GCHG
);

    rr_state_e       state_r;
    logic [IDXW-1:0] s_r;
    logic            gv_r;
    logic            gchg_r;
    logic [IDXW-1:0] ptr_r;

    logic [NREQ-1:0] excl_s;
    logic            pick_hit_s;
    logic [IDXW-1:0] pick_idx_s;

`ifdef RR_TIMEOUT_EN
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_MAX - 1);
    localparam logic [CNTW-1:0] HOLD_TOP  = CNTW'(HOLD_MAX);
    localparam logic [CNTW-1:0] HCNT_ONE  = CNTW'(1);

    logic [CNTW-1:0] hcnt_r;
`else
    // No hold counter in this build; the hold parameters only need to be legal.
    if ((HOLD_MAX < 1) || (HOLD_MAX >= (1 << CNTW))) begin : g_hold_cfg_unused
    end
`endif

    // The current owner never competes for its own replacement.
    always_comb begin
        excl_s = {NREQ{1'b0}};
        if (state_r == GRANT) begin
            excl_s = idx_onehot(s_r);
        end else begin
            excl_s = {NREQ{1'b0}};
        end
    end

    rr_pick u_pick (
        .REQ  (REQ),
        .PTR  (ptr_r),
        .EXCL (excl_s),
        .HIT  (pick_hit_s),
        .IDX  (pick_idx_s)
    );

    // Grant FSM: issues, hands over, holds and releases the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            s_r     <= {IDXW{1'b0}};
            gv_r    <= 1'b0;
            gchg_r  <= 1'b0;
            ptr_r   <= {IDXW{1'b0}};
`ifdef RR_TIMEOUT_EN
            hcnt_r  <= {CNTW{1'b0}};
`endif
        end else begin
            gchg_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_hit_s) begin
                        state_r <= GRANT;
                        s_r     <= pick_idx_s;
                        gv_r    <= 1'b1;
                        gchg_r  <= 1'b1;
                        ptr_r   <= pick_idx_s + 2'd1;
`ifdef RR_TIMEOUT_EN
                        hcnt_r  <= {CNTW{1'b0}};
`endif
                    end else begin
                        state_r <= IDLE;
                        gv_r    <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!REQ[s_r]) begin
                        // Owner released: hand over without a bubble, or go idle.
                        if (pick_hit_s) begin
                            s_r    <= pick_idx_s;
                            gv_r   <= 1'b1;
                            gchg_r <= 1'b1;
                            ptr_r  <= pick_idx_s + 2'd1;
`ifdef RR_TIMEOUT_EN
                            hcnt_r <= {CNTW{1'b0}};
`endif
                        end else begin
                            state_r <= IDLE;
                            gv_r    <= 1'b0;
                        end
                    end else begin
`ifdef RR_TIMEOUT_EN
                        // Forced rotation once the hold limit is reached and someone waits;
                        // >= keeps a saturated counter from blocking a late requester.
                        if ((hcnt_r >= HOLD_LAST) && pick_hit_s) begin
                            s_r    <= pick_idx_s;
                            gv_r   <= 1'b1;
                            gchg_r <= 1'b1;
                            ptr_r  <= pick_idx_s + 2'd1;
                            hcnt_r <= {CNTW{1'b0}};
                        end else if (hcnt_r != HOLD_TOP) begin
                            hcnt_r <= hcnt_r + HCNT_ONE;
                        end else begin
                            hcnt_r <= hcnt_r;
                        end
`else
                        s_r <= s_r;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gv_r    <= 1'b0;
                end
            endcase
        end
    end

    assign S    = s_r;
    assign GV   = gv_r;
    assign GCHG = gchg_r;

endmodule

// File: tb/tb_rr_grant_sel.sv
// Self-checking bench for rr_grant_sel: directed scenarios followed by
// randomized requests, all compared against a behavioural arbiter model.
module tb_rr_grant_sel;

    localparam int HOLD_MAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] s;
    logic       gv;
    logic       gchg;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_ptr  = 0;
    int m_own  = 0;
    int m_hold = 0;
    bit m_gv   = 1'b0;
    bit m_chg  = 1'b0;

    rr_grant_sel #(.HOLD_MAX(HOLD_MAX), .CNTW(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .REQ  (req),
        .S    (s),
        .GV   (gv),
        .GCHG (gchg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_grant(input int who);
        m_own  = who;
        m_gv   = 1'b1;
        m_chg  = 1'b1;
        m_ptr  = (who + 1) % 4;
        m_hold = 0;
    endfunction

    // Next-cycle behaviour of an ideal round-robin arbiter.
    function automatic void model_step(input logic [3:0] r, input bit rs);
        int cand;
        if (rs) begin
            m_ptr = 0; m_own = 0; m_hold = 0; m_gv = 1'b0; m_chg = 1'b0;
            return;
        end
        m_chg = 1'b0;
        cand = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (cand < 0 && r[i] && !(m_gv && i == m_own)) cand = i;
        end
        if (!m_gv) begin
            if (cand >= 0) model_grant(cand);
        end else if (!r[m_own]) begin
            if (cand >= 0) model_grant(cand);
            else m_gv = 1'b0;
        end else begin
`ifdef RR_TIMEOUT_EN
            if (m_hold >= HOLD_MAX - 1 && cand >= 0) model_grant(cand);
            else if (m_hold < HOLD_MAX) m_hold++;
`endif
        end
    endfunction

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic step(input logic [3:0] r, input bit rs);
        @(negedge clk);
        req = r;
        rst = rs;
        model_step(r, rs);
        @(posedge clk);
        #1;
        check("S", int'(s), m_own);
        check("GV", int'(gv), int'(m_gv));
        check("GCHG", int'(gchg), int'(m_chg));
    endtask

    initial begin
        int seq[5];
        int nchg;
        int cyc;
        logic [3:0] r;

        // Reset state
        step(4'b0000, 1'b1);
        check("reset_gv", int'(gv), 0);
        check("reset_s", int'(s), 0);

        // Reset asserted mid-grant with all requests high
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("pre_reset_gv", int'(gv), 1);
        step(4'b1111, 1'b1);
        check("midrst_gv", int'(gv), 0);
        check("midrst_s", int'(s), 0);
        check("midrst_gchg", int'(gchg), 0);
        step(4'b1111, 1'b0);
        check("postrst_s", int'(s), 0);
        check("postrst_gv", int'(gv), 1);

        // Rotation: owner releases one cycle after each grant
        seq = '{0, 1, 2, 3, 0};
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b0);
        check("rot_s0", int'(s), seq[0]);
        for (int g = 1; g < 5; g++) begin
            r = 4'b1111;
            r[m_own] = 1'b0;
            step(r, 1'b0);
            check("rot_s", int'(s), seq[g]);
            check("rot_gv", int'(gv), 1);
            check("rot_gchg", int'(gchg), 1);
        end

        // Skip and wrap from pointer 3
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0101, 1'b0);
        check("wrap_s0", int'(s), 0);
        step(4'b0100, 1'b0);
        check("wrap_s2", int'(s), 2);
        check("wrap_gv", int'(gv), 1);
        step(4'b0000, 1'b0);
        check("wrap_idle_gv", int'(gv), 0);
        check("wrap_idle_s", int'(s), 2);

        // Lone holder
        step(4'b0000, 1'b1);
        nchg = 0;
        for (int c = 0; c < 40; c++) begin
            step(4'b0010, 1'b0);
            if (gchg) nchg++;
        end
        check("lone_s", int'(s), 1);
        check("lone_gchg_count", nchg, 1);

        // Timeout / hold behaviour
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        check("to_first", int'(s), 2);
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            step(4'b1100, 1'b0);
            if (cyc == 0 && s == 2'd3) cyc = c;
        end
`ifdef RR_TIMEOUT_EN
        check("to_switch_cycle", cyc, HOLD_MAX);
`else
        check("to_no_switch", cyc, 0);
        step(4'b1000, 1'b0);
        check("to_release_s", int'(s), 3);
`endif

        // Randomized traffic, mostly keeping the owner's request up
        for (int c = 0; c < 600; c++) begin
            r = 4'($urandom_range(0, 15));
            if (m_gv && $urandom_range(0, 3) != 0) r[m_own] = 1'b1;
            step(r, ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
